// File: rtl/ariane_pkg.sv
// Core-wide frontend types: fetch entries handed to decode, plus queue sizing.
package ariane_pkg;
  localparam int unsigned FETCH_QUEUE_DEPTH = 4;

  typedef enum logic [2:0] {
    NoCF   = 3'd0,
    Branch = 3'd1,
    Jump   = 3'd2,
    JumpR  = 3'd3,
    Return = 3'd4
  } cf_t;

  typedef struct packed {
    cf_t                     cf;
    logic [riscv::VLEN-1:0]  predict_address;
  } branchpredict_sbe_t;

  typedef struct packed {
    logic [riscv::XLEN-1:0]  cause;
    logic [riscv::XLEN-1:0]  tval;
    logic                    valid;
  } exception_t;

  typedef struct packed {
    logic [riscv::VLEN-1:0]  address;
    logic [31:0]             instruction;
    branchpredict_sbe_t      branch_predict;
    exception_t              ex;
  } fetch_entry_t;

  // A 16-bit parcel is compressed unless its two LSBs are both set.
  function automatic logic is_compressed(input logic [1:0] lsb);
    return lsb != 2'b11;
  endfunction

  function automatic fetch_entry_t make_entry(input logic [riscv::VLEN-1:0] addr,
                                              input logic [31:0]            instr);
    fetch_entry_t e;
    e             = '0;
    e.address     = addr;
    e.instruction = instr;
    return e;
  endfunction
endpackage

// File: rtl/riscv_pkg.sv
// RISC-V architectural widths shared across the frontend.
package riscv;
  localparam int unsigned VLEN = 32;
  localparam int unsigned XLEN = 32;
endpackage

// File: rtl/fetch_entry_queue_instr_realigner.sv
// Combinational split of one fetch word into up to two in-order instructions,
// stitching in a 32-bit instruction whose lower half arrived with the previous word.
module instr_realigner
  import ariane_pkg::*;
(
  input  logic [31:0]             data_i,
  input  logic [riscv::VLEN-1:0]  addr_i,
  input  logic                    ex_valid_i,
  input  logic [riscv::XLEN-1:0]  ex_cause_i,
  input  logic                    pend_valid_i,
  input  logic [15:0]             pend_half_i,
  input  logic [riscv::VLEN-1:0]  pend_addr_i,
  output fetch_entry_t            entry0_c,
  output logic                    valid0_c,
  output fetch_entry_t            entry1_c,
  output logic                    valid1_c,
  output logic                    pend_valid_c,
  output logic [15:0]             pend_half_c,
  output logic [riscv::VLEN-1:0]  pend_addr_c
);

  logic                   do_upper;
  logic [riscv::VLEN-1:0] up_addr;
  logic [15:0]            upper;
  logic [15:0]            lower;

  assign upper = data_i[31:16];
  assign lower = data_i[15:0];

  always_comb begin
    entry0_c     = '0;
    valid0_c     = 1'b0;
    entry1_c     = '0;
    valid1_c     = 1'b0;
    pend_valid_c = 1'b0;
    pend_half_c  = '0;
    pend_addr_c  = '0;
    do_upper     = 1'b0;
    up_addr      = addr_i + riscv::VLEN'(2);

    if (ex_valid_i) begin
      // A faulting word collapses to a single entry that also absorbs any pending half.
      entry0_c          = make_entry(pend_valid_i ? pend_addr_i : addr_i, 32'h0);
      entry0_c.ex.valid = 1'b1;
      entry0_c.ex.cause = ex_cause_i;
      entry0_c.ex.tval  = riscv::XLEN'(addr_i);
      valid0_c          = 1'b1;
    end else begin
      if (pend_valid_i && (addr_i == pend_addr_i + riscv::VLEN'(2))) begin
        entry0_c = make_entry(pend_addr_i, {lower, pend_half_i});
        valid0_c = 1'b1;
        do_upper = 1'b1;
      end else if (!addr_i[1]) begin
        valid0_c = 1'b1;
        if (is_compressed(lower[1:0])) begin
          entry0_c = make_entry(addr_i, {16'h0, lower});
          do_upper = 1'b1;
        end else begin
          entry0_c = make_entry(addr_i, data_i);
        end
      end else begin
        do_upper = 1'b1;
        up_addr  = addr_i;
      end

      // Upper parcel either completes as compressed or starts a straddling instruction.
      if (do_upper) begin
        if (is_compressed(upper[1:0])) begin
          if (valid0_c) begin
            entry1_c = make_entry(up_addr, {16'h0, upper});
            valid1_c = 1'b1;
          end else begin
            entry0_c = make_entry(up_addr, {16'h0, upper});
            valid0_c = 1'b1;
          end
        end else begin
          pend_valid_c = 1'b1;
          pend_half_c  = upper;
          pend_addr_c  = up_addr;
        end
      end
    end
  end

endmodule

// File: rtl/fetch_entry_queue.sv
// Realigns fetch words into instructions and queues them for decode.
// Define FETCH_QUEUE_BYPASS_EN to forward the first entry combinationally into an empty queue.
module fetch_entry_queue
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    fetch_valid_i,
  output logic                    fetch_ready_o,
  input  logic [riscv::VLEN-1:0]  fetch_addr_i,
  input  logic [31:0]             fetch_data_i,
  input  logic                    fetch_ex_valid_i,
  input  logic [riscv::XLEN-1:0]  fetch_ex_cause_i,
  output fetch_entry_t            fetch_entry_o,
  output logic                    fetch_entry_valid_o,
  input  logic                    fetch_entry_ready_i
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t           mem_q [DEPTH];
  fetch_entry_t           mem_d [DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [15:0]            pend_half_q, pend_half_d;
  logic [riscv::VLEN-1:0] pend_addr_q, pend_addr_d;
  logic                   init_q;

  fetch_entry_t           re_entry0, re_entry1;
  logic                   re_valid0, re_valid1;
  logic                   re_pend_valid;
  logic [15:0]            re_pend_half;
  logic [riscv::VLEN-1:0] re_pend_addr;

  logic                   accept, pop, byp;
  fetch_entry_t           push_a, push_b;
  logic                   push_a_v, push_b_v;
  logic [1:0]             n_push;

  instr_realigner u_realigner (
    .data_i       (fetch_data_i),
    .addr_i       (fetch_addr_i),
    .ex_valid_i   (fetch_ex_valid_i),
    .ex_cause_i   (fetch_ex_cause_i),
    .pend_valid_i (pend_valid_q),
    .pend_half_i  (pend_half_q),
    .pend_addr_i  (pend_addr_q),
    .entry0_c     (re_entry0),
    .valid0_c     (re_valid0),
    .entry1_c     (re_entry1),
    .valid1_c     (re_valid1),
    .pend_valid_c (re_pend_valid),
    .pend_half_c  (re_pend_half),
    .pend_addr_c  (re_pend_addr)
  );

  // Room for a worst-case pair is judged on the registered count only.
  assign fetch_ready_o = init_q && !flush_i && ((CW'(DEPTH) - count_q) >= CW'(2));
  assign accept        = fetch_valid_i && fetch_ready_o;
  assign pop           = (count_q != '0) && fetch_entry_ready_i;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = (count_q == '0) && accept && re_valid0;
`else
  assign byp = 1'b0;
`endif

  assign fetch_entry_valid_o = (count_q != '0) || byp;
  assign fetch_entry_o       = byp ? re_entry0 : mem_q[rd_ptr_q];

  // Select what gets written; a consumed bypass entry is skipped.
  always_comb begin
    push_a   = re_entry0;
    push_a_v = accept && re_valid0;
    push_b   = re_entry1;
    push_b_v = accept && re_valid1;
    if (byp && fetch_entry_ready_i) begin
      push_a   = re_entry1;
      push_a_v = accept && re_valid1;
      push_b_v = 1'b0;
    end
    n_push = {1'b0, push_a_v} + {1'b0, push_b_v};
  end

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    pend_valid_d = pend_valid_q;
    pend_half_d  = pend_half_q;
    pend_addr_d  = pend_addr_q;

    if (flush_i) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      pend_valid_d = 1'b0;
      pend_half_d  = '0;
      pend_addr_d  = '0;
    end else begin
      if (push_a_v) mem_d[wr_ptr_q] = push_a;
      if (push_b_v) mem_d[wr_ptr_q + PW'(1)] = push_b;
      wr_ptr_d = wr_ptr_q + PW'(n_push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(n_push) - CW'(pop);
      if (accept) begin
        pend_valid_d = re_pend_valid;
        pend_half_d  = re_pend_half;
        pend_addr_d  = re_pend_addr;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_half_q  <= '0;
      pend_addr_q  <= '0;
      init_q       <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pend_valid_q <= pend_valid_d;
      pend_half_q  <= pend_half_d;
      pend_addr_q  <= pend_addr_d;
      init_q       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_entry_queue.sv
// Directed plus random stimulus for fetch_entry_queue, checked against a
// halfword-stream reference model of the realignment and queue occupancy.
module tb_fetch_entry_queue;
  import ariane_pkg::*;

  localparam int DEPTH = 4;

  logic         clk_i;
  logic         rst_ni;
  logic         flush_i;
  logic         fetch_valid_i;
  logic         fetch_ready_o;
  logic [31:0]  fetch_addr_i;
  logic [31:0]  fetch_data_i;
  logic         fetch_ex_valid_i;
  logic [31:0]  fetch_ex_cause_i;
  fetch_entry_t fetch_entry_o;
  logic         fetch_entry_valid_o;
  logic         fetch_entry_ready_i;

  fetch_entry_queue #(.DEPTH(DEPTH)) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .flush_i             (flush_i),
    .fetch_valid_i       (fetch_valid_i),
    .fetch_ready_o       (fetch_ready_o),
    .fetch_addr_i        (fetch_addr_i),
    .fetch_data_i        (fetch_data_i),
    .fetch_ex_valid_i    (fetch_ex_valid_i),
    .fetch_ex_cause_i    (fetch_ex_cause_i),
    .fetch_entry_o       (fetch_entry_o),
    .fetch_entry_valid_o (fetch_entry_valid_o),
    .fetch_entry_ready_i (fetch_entry_ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: expected entries in output order plus the carried half.
  fetch_entry_t mq[$];
  logic         m_pv = 1'b0;
  logic [15:0]  m_ph = '0;
  logic [31:0]  m_pa = '0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic fetch_entry_t ent(input logic [31:0] a, input logic [31:0] ins);
    fetch_entry_t e;
    e             = '0;
    e.address     = a;
    e.instruction = ins;
    return e;
  endfunction

  // Walk the word's halfwords in address order, assembling instructions.
  task automatic model_word(input logic [31:0] a, input logic [31:0] d,
                            input logic ex, input logic [31:0] cause);
    fetch_entry_t e;
    logic [31:0]  base;
    logic [15:0]  h;
    int           i;
    if (ex) begin
      e          = ent(m_pv ? m_pa : a, 32'h0);
      e.ex.valid = 1'b1;
      e.ex.cause = cause;
      e.ex.tval  = a;
      mq.push_back(e);
      m_pv = 1'b0;
      return;
    end
    if (m_pv && a != m_pa + 32'd2) m_pv = 1'b0;
    base = {a[31:2], 2'b00};
    i    = a[1] ? 1 : 0;
    while (i < 2) begin
      h = (i == 0) ? d[15:0] : d[31:16];
      if (m_pv) begin
        mq.push_back(ent(m_pa, {h, m_ph}));
        m_pv = 1'b0;
        i++;
      end else if (h[1:0] != 2'b11) begin
        mq.push_back(ent(base + 32'(2 * i), {16'h0, h}));
        i++;
      end else if (i == 1) begin
        m_pv = 1'b1;
        m_ph = h;
        m_pa = base + 32'd2;
        i++;
      end else begin
        mq.push_back(ent(base, d));
        i += 2;
      end
    end
  endtask

  // One clock cycle: drive, sample mid-cycle, check, advance the model.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic ex, input logic [31:0] c, input logic cr,
                      input logic fl, output logic acc);
    logic exp_ready;
    @(negedge clk_i);
    fetch_valid_i       = v;
    fetch_addr_i        = a;
    fetch_data_i        = d;
    fetch_ex_valid_i    = ex;
    fetch_ex_cause_i    = c;
    fetch_entry_ready_i = cr;
    flush_i             = fl;
    #1;
    exp_ready = !fl && ((DEPTH - mq.size()) >= 2);
    chk("fetch_ready", 256'(fetch_ready_o), 256'(exp_ready));
    chk("entry_valid", 256'(fetch_entry_valid_o), 256'(mq.size() != 0));
    if (mq.size() != 0 && cr && !fl) begin
      chk("entry", 256'(fetch_entry_o), 256'(mq[0]));
      void'(mq.pop_front());
    end
    acc = v && exp_ready;
    if (fl) begin
      mq.delete();
      m_pv = 1'b0;
    end else if (acc) begin
      model_word(a, d, ex, c);
    end
  endtask

  task automatic idle(input logic cr);
    logic acc;
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, cr, 1'b0, acc);
  endtask

  task automatic word(input logic [31:0] a, input logic [31:0] d, input logic cr);
    logic acc;
    step(1'b1, a, d, 1'b0, 32'h0, cr, 1'b0, acc);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] a, input logic [31:0] ins);
    chk({tag, "_valid"}, 256'(fetch_entry_valid_o), 256'(1'b1));
    chk({tag, "_addr"}, 256'(fetch_entry_o.address), 256'(a));
    chk({tag, "_instr"}, 256'(fetch_entry_o.instruction), 256'(ins));
  endtask

  initial begin
    fetch_entry_t exp_e;
    logic         acc;
    logic [31:0]  ra, rd, next_a, rc;
    logic [15:0]  h0, h1;
    logic         rv, rex, rfl, rcr;

    rst_ni = 1'b0;
    flush_i = 1'b0;
    fetch_valid_i = 1'b0;
    fetch_addr_i = '0;
    fetch_data_i = '0;
    fetch_ex_valid_i = 1'b0;
    fetch_ex_cause_i = '0;
    fetch_entry_ready_i = 1'b0;

    repeat (3) @(negedge clk_i);
    chk("rst_ready", 256'(fetch_ready_o), 256'(1'b0));
    chk("rst_valid", 256'(fetch_entry_valid_o), 256'(1'b0));
    chk("rst_entry", 256'(fetch_entry_o), 256'(0));
    rst_ni = 1'b1;
    @(posedge clk_i);

    // Two compressed instructions from one aligned word.
    word(32'h8000_0000, 32'h4585_4501, 1'b0);
    idle(1'b1);
    chk_head("pair_lo", 32'h8000_0000, 32'h0000_4501);
    idle(1'b1);
    chk_head("pair_hi", 32'h8000_0002, 32'h0000_4585);

    // Single 32-bit instruction.
    word(32'h0000_1000, 32'h0000_0513, 1'b1);
    idle(1'b1);
    chk_head("full32", 32'h0000_1000, 32'h0000_0513);

    // 32-bit instruction straddling two words.
    word(32'h0000_1000, 32'h0513_4501, 1'b1);
    word(32'h0000_1004, 32'h4585_0000, 1'b1);
    chk_head("strad_a", 32'h0000_1000, 32'h0000_4501);
    idle(1'b1);
    chk_head("strad_b", 32'h0000_1002, 32'h0000_0513);
    idle(1'b1);
    chk_head("strad_c", 32'h0000_1006, 32'h0000_4585);
    idle(1'b1);

    // Backpressure: queue fills, ready drops, then returns after pops.
    word(32'h0000_3000, 32'h4501_4501, 1'b0);
    word(32'h0000_3004, 32'h4585_4585, 1'b0);
    word(32'h0000_3008, 32'h4601_4601, 1'b0);
    chk("bp_full_ready", 256'(fetch_ready_o), 256'(1'b0));
    idle(1'b1);
    idle(1'b1);
    word(32'h0000_3008, 32'h4601_4601, 1'b0);
    repeat (5) idle(1'b1);

    // Fault word absorbs a pending upper half.
    word(32'h0000_1000, 32'h0513_4501, 1'b1);
    step(1'b1, 32'h0000_1004, 32'h0, 1'b1, 32'd1, 1'b1, 1'b0, acc);
    idle(1'b1);
    exp_e          = ent(32'h0000_1002, 32'h0);
    exp_e.ex.valid = 1'b1;
    exp_e.ex.cause = 32'd1;
    exp_e.ex.tval  = 32'h0000_1004;
    chk("ex_entry", 256'(fetch_entry_o), 256'(exp_e));
    idle(1'b1);

    // Flush with three queued entries and a pending half.
    word(32'h0000_3000, 32'h4501_4501, 1'b0);
    word(32'h0000_3004, 32'h0513_4501, 1'b0);
    step(1'b1, 32'h0000_3008, 32'h4585_4585, 1'b0, 32'h0, 1'b0, 1'b1, acc);
    idle(1'b0);
    chk("flush_valid", 256'(fetch_entry_valid_o), 256'(1'b0));
    word(32'h0000_2002, 32'h4501_0000, 1'b1);
    idle(1'b1);
    chk_head("post_flush", 32'h0000_2002, 32'h0000_4501);
    idle(1'b1);
    chk("post_flush_empty", 256'(fetch_entry_valid_o), 256'(1'b0));

    // Random mostly-sequential stream with jumps, faults, flushes and stalls.
    next_a = 32'h0000_4000;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) < 12)
        ra = {20'h00005, 10'($urandom), 1'($urandom), 1'b0};
      else
        ra = next_a;
      h0 = 16'($urandom);
      h1 = 16'($urandom);
      if ($urandom_range(0, 1) == 1) h0[1:0] = 2'b11;
      if ($urandom_range(0, 1) == 1) h1[1:0] = 2'b11;
      rd  = {h1, h0};
      rv  = ($urandom_range(0, 99) < 75);
      rex = ($urandom_range(0, 99) < 5);
      rfl = ($urandom_range(0, 99) < 3);
      rcr = ($urandom_range(0, 99) < 60);
      rc  = 32'($urandom_range(0, 15));
      step(rv, ra, rd, rex, rc, rcr, rfl, acc);
      if (acc && !rfl) next_a = {ra[31:2], 2'b00} + 32'd4;
      else if (rfl) next_a = {20'h00006, 10'($urandom), 2'b00};
    end
    repeat (8) idle(1'b1);
    chk("drained", 256'(fetch_entry_valid_o), 256'(1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
